// File: rtl/mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the 4-requester round-robin mux arbiter.
//   NUM_REQ  : number of requesters sharing the mux
//   IDX_W    : width of an owner index (mux select width)
//   state_t  : arbiter state (IDLE / GRANT)
//   onehot4  : owner index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// ---------------------------------------------------------------------------
// rr_pick_4
// Combinational round-robin picker. Searches req starting at ptr+1 and
// wrapping, so the requester at ptr is considered last.
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : last owner (lowest priority)
//   idx   [1:0] out : winning requester index (0 when nothing found)
//   found       out : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick_4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // 2-bit addition wraps naturally, giving (ptr + k) mod 4.
      logic [IDX_W-1:0] cand;
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter that shares one 4:1 bit mux among four requesters.
// Ownership lasts for a burst, ending on last_i, on the owner dropping its
// request, or when the hold counter reaches HOLD_MAX (0 disables the limit).
// All outputs come straight from registers.
//   clk_i      in      : clock
//   rst_i      in      : synchronous active-high reset
//   req_i[3:0] in      : request per requester
//   last_i     in      : owner's final beat (ignored while idle)
//   grant_o    out [4] : one-hot grant, 0000 when idle
//   sel0_o     out     : owner index LSB (mux select within a pair)
//   sel1_o     out     : owner index MSB (mux select between pairs)
//   valid_o    out     : a grant is active
//   timeout_o  out     : one-cycle pulse after a HOLD_MAX force-release
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               sel0_o,
  output logic               sel1_o,
  output logic               valid_o,
  output logic               timeout_o
);

  localparam bit LIMIT_EN = (HOLD_MAX != 0);
  localparam int CNT_W    = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  // With the limit disabled the counter is held at a constant and folds away.
  localparam logic [CNT_W-1:0] CNT_ONE = LIMIT_EN ? CNT_W'(1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  state_t           w_state_n;
  logic [IDX_W-1:0] w_idx_n;
  logic [IDX_W-1:0] w_ptr_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_timeout_n;

  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_limit;
  logic             w_rel;

  // The picker searches from the current pointer in both states: in IDLE the
  // pointer is the previous owner, in GRANT it is the current owner, so the
  // releasing owner is always considered last.
  rr_pick_4 u_pick (
    .req   (req_i),
    .ptr   (r_ptr),
    .idx   (w_pick),
    .found (w_found)
  );

  assign w_limit = LIMIT_EN && (r_cnt == CNT_MAX);
  assign w_rel   = last_i | ~req_i[r_idx] | w_limit;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_ptr     <= w_ptr_n;
      r_cnt     <= w_cnt_n;
      r_timeout <= w_timeout_n;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_ptr_n     = r_ptr;
    w_cnt_n     = r_cnt;
    w_timeout_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_n = GRANT;
          w_idx_n   = w_pick;
          w_ptr_n   = w_pick;
          w_cnt_n   = CNT_ONE;
        end
      end
      GRANT: begin
        if (w_rel) begin
          // Only a pure counter release (owner still busy, no last beat)
          // is reported as a timeout.
          w_timeout_n = w_limit & ~last_i & req_i[r_idx];
          if (w_found) begin
            w_idx_n = w_pick;
            w_ptr_n = w_pick;
            w_cnt_n = CNT_ONE;
          end else begin
            // Select lines keep the last owner while idle.
            w_state_n = IDLE;
            w_cnt_n   = '0;
          end
        end else if (LIMIT_EN && (r_cnt != CNT_MAX)) begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Output logic, decoded from registers only
  always_comb begin
    valid_o   = (r_state == GRANT);
    grant_o   = valid_o ? onehot4(r_idx) : '0;
    sel0_o    = r_idx[0];
    sel1_o    = r_idx[1];
    timeout_o = LIMIT_EN ? r_timeout : 1'b0;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int HOLD = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = '0;
  logic       last_i = 1'b0;
  logic [3:0] grant_o;
  logic       sel0_o, sel1_o, valid_o, timeout_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner number, whether a grant is active, beats held.
  int m_owner, m_ptr, m_cnt;
  bit m_valid, m_to;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .last_i    (last_i),
    .grant_o   (grant_o),
    .sel0_o    (sel0_o),
    .sel1_o    (sel1_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_edge(input logic [3:0] req, input logic last, input logic rst);
    bit rel;
    bit to_n;
    int win;
    if (rst) begin
      m_valid = 0; m_owner = 0; m_ptr = 3; m_cnt = 0; m_to = 0;
      return;
    end
    to_n = 0;
    rel  = 1;
    if (m_valid) begin
      rel  = last || !req[m_owner] || (m_cnt == HOLD);
      to_n = !last && req[m_owner] && (m_cnt == HOLD);
    end
    if (rel) begin
      win = -1;
      for (int k = 1; k <= 4; k++)
        if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      if (win >= 0) begin
        m_valid = 1; m_owner = win; m_ptr = win; m_cnt = 1;
      end else begin
        m_valid = 0;
      end
    end else if (m_cnt < HOLD) begin
      m_cnt++;
    end
    m_to = to_n;
  endfunction

  task automatic step(input logic [3:0] req, input logic last, input logic rst);
    req_i = req; last_i = last; rst_i = rst;
    @(posedge clk_i);
    model_edge(req, last, rst);
    #1;
    check("grant", grant_o, m_valid ? (32'd1 << m_owner) : 32'd0);
    check("sel", {sel1_o, sel0_o}, m_owner);
    check("valid", valid_o, m_valid);
    check("timeout", timeout_o, m_to);
  endtask

  initial begin
    logic [3:0] exp4 [0:4];
    logic [3:0] r;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    check("rst_grant", grant_o, 4'b0000);
    check("rst_valid", valid_o, 1'b0);
    check("rst_sel", {sel1_o, sel0_o}, 2'b00);

    // 1: alternating pair, no idle gap
    exp4[0] = 4'b0001; exp4[1] = 4'b0100; exp4[2] = 4'b0001; exp4[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, m_valid, 1'b0);
      check("t1_grant", grant_o, exp4[i]);
    end

    // 2: all requesting, last every beat
    step(4'b0000, 1'b0, 1'b1);
    exp4[0] = 4'b0001; exp4[1] = 4'b0010; exp4[2] = 4'b0100; exp4[3] = 4'b1000; exp4[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, m_valid, 1'b0);
      check("t2_grant", grant_o, exp4[i]);
      check("t2_sel", {sel1_o, sel0_o}, i % 4);
    end

    // 3: sole requester hits the hold limit repeatedly
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      check("t3_grant", grant_o, 4'b0010);
      check("t3_timeout", timeout_o, (i > 0 && i % HOLD == 0) ? 1'b1 : 1'b0);
    end

    // 4: owner 2 drops, everything idle, select holds
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("t4_valid", valid_o, 1'b0);
    check("t4_grant", grant_o, 4'b0000);
    check("t4_sel", {sel1_o, sel0_o}, 2'b10);
    check("t4_timeout", timeout_o, 1'b0);

    // 5: reset in the middle of a grant
    step(4'b1000, 1'b0, 1'b0);
    check("t5_pre", grant_o, 4'b1000);
    step(4'b1000, 1'b0, 1'b1);
    check("t5_rst_grant", grant_o, 4'b0000);
    check("t5_rst_sel", {sel1_o, sel0_o}, 2'b00);
    step(4'b1000, 1'b0, 1'b0);
    check("t5_regrant", grant_o, 4'b1000);

    // 6: last coincides with the limit
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < HOLD; i++) step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    check("t6_timeout", timeout_o, 1'b0);
    check("t6_grant", grant_o, 4'b0010);

    // Random traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom);
      if ($urandom_range(3) == 0) r = 4'b0000;
      step(r, ($urandom_range(3) == 0), ($urandom_range(127) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
